// File: rtl/insert_stuff.sv
// MJPEG output stage: splits packed words into bytes, inserts 0x00 after each non-exempt 0xFF,
// and buffers the byte stream in a first-word-fall-through FIFO.
module insert_stuff #(
    parameter int DEPTH = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enqueue,
    input  logic [31:0] wdata,
    input  logic [31:0] wdata_nostuff,
    output logic        ready,
    input  logic        dequeue,
    output logic [7:0]  rdata
);

    localparam int AW = $clog2(DEPTH);

    logic              s1_valid;
    logic [31:0]       s1_data;
    logic [31:0]       s1_mask;

    logic [7:0]        exp_bytes [8];
    logic [3:0]        exp_cnt;
    logic [7:0]        cur_byte;
    logic              cur_exempt;

    logic [7:0]        mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       count;
    logic [AW:0]       free_space;
    logic [AW:0]       cnt_ext;
    logic [7:0]        last_byte;
    logic              do_write;
    logic              do_read;

    // Expand the registered word MSB byte first, appending a stuff byte after each unexempt 0xFF
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            exp_bytes[i] = 8'h00;
        end
        exp_cnt    = 4'd0;
        cur_byte   = 8'h00;
        cur_exempt = 1'b0;
        for (int b = 0; b < 4; b++) begin
            cur_byte   = s1_data[31-8*b -: 8];
            cur_exempt = (s1_mask[31-8*b -: 8] == 8'hFF);
            exp_bytes[exp_cnt[2:0]] = cur_byte;
            exp_cnt = exp_cnt + 4'd1;
            if (cur_byte == 8'hFF && !cur_exempt) begin
                exp_bytes[exp_cnt[2:0]] = 8'h00;
                exp_cnt = exp_cnt + 4'd1;
            end
        end
    end

    // A word is written whole or not at all, judged against space before this cycle's dequeue
    assign cnt_ext    = {{(AW-3){1'b0}}, exp_cnt};
    assign free_space = (AW+1)'(DEPTH) - count;
    assign do_write   = s1_valid && (cnt_ext <= free_space);
    assign ready      = (count != '0);
    assign do_read    = dequeue && ready;
    assign rdata      = ready ? mem[rd_ptr] : last_byte;

    always_ff @(posedge clk) begin
        if (!rst) begin
            s1_valid  <= 1'b0;
            s1_data   <= 32'h0;
            s1_mask   <= 32'h0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            last_byte <= 8'h00;
        end else begin
            s1_valid <= enqueue;
            if (enqueue) begin
                s1_data <= wdata;
                s1_mask <= wdata_nostuff;
            end
            if (do_write) begin
                wr_ptr <= wr_ptr + AW'(exp_cnt);
            end
            if (do_read) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + (do_write ? cnt_ext : '0) - (do_read ? (AW+1)'(1) : '0);
            if (ready) begin
                last_byte <= rdata;
            end
        end
    end

    // Storage is left unreset; occupancy alone decides what is valid
    always_ff @(posedge clk) begin
        if (rst && do_write) begin
            for (int i = 0; i < 8; i++) begin
                if (4'(i) < exp_cnt) begin
                    mem[wr_ptr + AW'(i)] <= exp_bytes[i];
                end
            end
        end
    end

endmodule

// File: tb/tb_insert_stuff.sv
// Bench for insert_stuff: directed and random words checked each cycle against a byte-queue model.
module tb_insert_stuff;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        enqueue = 1'b0;
    logic [31:0] wdata = 32'h0;
    logic [31:0] wdata_nostuff = 32'h0;
    logic        ready;
    logic        dequeue = 1'b0;
    logic [7:0]  rdata;

    int checks = 0;
    int passes = 0;

    logic [7:0]  model_q [$];
    logic [7:0]  word_q [$];
    logic        model_s1_valid = 1'b0;
    logic [31:0] model_s1_data = 32'h0;
    logic [31:0] model_s1_mask = 32'h0;
    logic [7:0]  last_exp = 8'h00;

    logic [7:0]  exp_seq [$];
    logic [7:0]  got_seq [$];
    string       cur_tag = "reset";

    insert_stuff #(.DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst           (rst),
        .enqueue       (enqueue),
        .wdata         (wdata),
        .wdata_nostuff (wdata_nostuff),
        .ready         (ready),
        .dequeue       (dequeue),
        .rdata         (rdata)
    );

    always #5 clk = ~clk;

    // The byte list a word contributes: each byte, plus a 0x00 after any 0xFF not marked exempt
    task automatic expandWord(input logic [31:0] d, input logic [31:0] m);
        logic [7:0] b;
        word_q.delete();
        for (int i = 3; i >= 0; i--) begin
            b = d[8*i +: 8];
            word_q.push_back(b);
            if (b == 8'hFF && m[8*i +: 8] != 8'hFF) word_q.push_back(8'h00);
        end
    endtask

    task automatic modelEdge(input logic en, input logic [31:0] d, input logic [31:0] m,
                             input logic deq, input logic rstv);
        int size_before;
        bit pop_ok;
        if (!rstv) begin
            model_q.delete();
            model_s1_valid = 1'b0;
            last_exp = 8'h00;
            return;
        end
        size_before = model_q.size();
        pop_ok = deq && (size_before > 0);
        if (model_s1_valid) begin
            expandWord(model_s1_data, model_s1_mask);
            if (DEPTH - size_before >= word_q.size()) begin
                foreach (word_q[i]) model_q.push_back(word_q[i]);
            end
        end
        if (pop_ok) void'(model_q.pop_front());
        model_s1_valid = en;
        model_s1_data = d;
        model_s1_mask = m;
    endtask

    task automatic checkOutput();
        logic       exp_ready;
        logic [7:0] exp_data;
        exp_ready = (model_q.size() != 0);
        exp_data = exp_ready ? model_q[0] : last_exp;
        last_exp = exp_data;
        checks++;
        assert (ready === exp_ready) passes++;
        else $error("[TB] FAIL %s ready: observed %b expected %b", cur_tag, ready, exp_ready);
        checks++;
        assert (rdata === exp_data) passes++;
        else $error("[TB] FAIL %s rdata: observed %h expected %h", cur_tag, rdata, exp_data);
    endtask

    // One clock: drive inputs, advance the model at the edge, then check just after it
    task automatic applyStimulus(input logic en, input logic [31:0] d, input logic [31:0] m,
                                 input logic deq);
        enqueue = en;
        wdata = d;
        wdata_nostuff = m;
        dequeue = deq;
        @(posedge clk);
        modelEdge(en, d, m, deq, rst);
        #1;
        checkOutput();
    endtask

    task automatic drainSeq(input int max_cycles);
        got_seq.delete();
        for (int c = 0; c < max_cycles; c++) begin
            if (!ready) break;
            got_seq.push_back(rdata);
            applyStimulus(1'b0, 32'h0, 32'h0, 1'b1);
        end
    endtask

    task automatic compareSeq();
        checks++;
        assert (got_seq.size() === exp_seq.size()) passes++;
        else $error("[TB] FAIL %s length: observed %0d expected %0d", cur_tag, got_seq.size(), exp_seq.size());
        for (int i = 0; i < got_seq.size() && i < exp_seq.size(); i++) begin
            checks++;
            assert (got_seq[i] === exp_seq[i]) passes++;
            else $error("[TB] FAIL %s byte%0d: observed %h expected %h", cur_tag, i, got_seq[i], exp_seq[i]);
        end
    endtask

    task automatic directedWord(input logic [31:0] d, input logic [31:0] m);
        applyStimulus(1'b1, d, m, 1'b0);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0);
        drainSeq(12);
        compareSeq();
    endtask

    function automatic logic [31:0] randWord();
        logic [31:0] w;
        for (int i = 0; i < 4; i++) w[8*i +: 8] = ($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom);
        return w;
    endfunction

    function automatic logic [31:0] randMask();
        logic [31:0] w;
        for (int i = 0; i < 4; i++) w[8*i +: 8] = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'h00;
        return w;
    endfunction

    initial begin
        $display("[TB] insert_stuff bench, DEPTH=%0d", DEPTH);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 32'h0, 32'h0, 1'b0);
        rst = 1'b1;
        cur_tag = "deq_empty";
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1);

        cur_tag = "plain";
        exp_seq = '{8'h12, 8'h34, 8'h56, 8'h78};
        directedWord(32'h12345678, 32'h0);

        cur_tag = "stuff";
        exp_seq = '{8'hFF, 8'h00, 8'h00, 8'hFF, 8'h00, 8'hAB};
        directedWord(32'hFF00FFAB, 32'h0);

        cur_tag = "all_ff";
        exp_seq = '{8'hFF, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00};
        directedWord(32'hFFFFFFFF, 32'h0);

        cur_tag = "exempt_all";
        exp_seq = '{8'hFF, 8'hD8, 8'hFF, 8'hE0};
        directedWord(32'hFFD8FFE0, 32'hFFFFFFFF);

        cur_tag = "exempt_msb";
        exp_seq = '{8'hFF, 8'hFF, 8'h00, 8'h12, 8'h34};
        directedWord(32'hFFFF1234, 32'hFF000000);

        cur_tag = "fill";
        applyStimulus(1'b1, 32'h11223344, 32'h0, 1'b0);
        applyStimulus(1'b1, 32'h55667788, 32'h0, 1'b0);
        applyStimulus(1'b1, 32'h99AABBCC, 32'h0, 1'b0);
        applyStimulus(1'b1, 32'hDDEEF001, 32'h0, 1'b0);
        applyStimulus(1'b1, 32'h0A0B0C0D, 32'h0, 1'b0);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0);
        cur_tag = "half_drain";
        for (int i = 0; i < 8; i++) applyStimulus(1'b0, 32'h0, 32'h0, 1'b1);
        cur_tag = "wrap";
        applyStimulus(1'b1, 32'h21222324, 32'h0, 1'b0);
        applyStimulus(1'b1, 32'h25262728, 32'h0, 1'b0);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0);
        exp_seq = '{8'h99, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hF0, 8'h01,
                    8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h27, 8'h28};
        drainSeq(24);
        compareSeq();

        cur_tag = "burst";
        for (int i = 0; i < 40; i++) applyStimulus(1'b1, randWord(), randMask(), 1'b1);
        cur_tag = "mid_reset";
        rst = 1'b0;
        applyStimulus(1'b1, randWord(), randMask(), 1'b1);
        rst = 1'b1;
        cur_tag = "post_reset";
        for (int i = 0; i < 80; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), randWord(), randMask(), 1'($urandom_range(0, 1)));
        end
        cur_tag = "final_drain";
        for (int i = 0; i < 40; i++) applyStimulus(1'b0, 32'h0, 32'h0, 1'b1);

        $display("[TB] %0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
